// File: rtl/uart_tx_cfg.sv
// UART transmitter: DATA_W data bits, optional even/odd parity, one or two stop bits.
// Define UART_TX_BREAK_EN to add the BRK_REQ port and a BREAK (line held low) state.
module uart_tx_cfg #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  output logic              DATA_READY,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic              BRK_REQ,
`endif
  output logic              TX_OUT,
  output logic              Busy
);
  localparam int BRK_CYC = (DATA_W + 3) * CLKS_PER_BIT;
  localparam int CW      = $clog2(BRK_CYC + 1);
  localparam int BW      = $clog2(DATA_W);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [CW-1:0] BRK_LAST  = CW'(BRK_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_en_q, par_en_d;
  logic                par_q, par_d;
  logic                stop2_q, stop2_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                bit_end;

  assign bit_end    = (clk_cnt_q == BIT_LAST);
  assign DATA_READY = (state_q == S_IDLE) && !rst;
  assign TX_OUT     = tx_q;
  assign Busy       = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_q     <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_d     = par_q;
    stop2_d   = stop2_q;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
`ifdef UART_TX_BREAK_EN
        if (BRK_REQ) state_d = S_BREAK;
        else
`endif
        if (DATA_VALID) begin
          state_d  = S_START;
          shift_d  = P_DATA;
          par_en_d = PAR_EN;
          par_d    = (^P_DATA) ^ PAR_TYP;
          stop2_d  = STOP2;
        end
      end
      S_START: begin
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
        if (bit_end) begin
          if (bit_cnt_q == BW'(stop2_q)) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      // Counter saturates at the minimum break length; a held BRK_REQ stretches the break.
      S_BREAK: begin
        if (clk_cnt_q == BRK_LAST) begin
          if (!BRK_REQ) begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            stop2_d   = 1'b0;
            state_d   = S_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Line outputs are registered from the next state so the start bit appears right after acceptance.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_q;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  tx_d = 1'b0;
`endif
      default:  tx_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg (DATA_W=8, CLKS_PER_BIT=4): per-cycle waveforms against a bit-list frame model.
module tb_uart_tx_cfg;
  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          DATA_READY;
  logic          PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
  logic          BRK = 1'b0;
  logic          TX_OUT, Busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_cfg #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
`ifdef UART_TX_BREAK_EN
    .BRK_REQ(BRK),
`endif
    .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // Frame as a list of line bits, each stretched to CPB cycles.
  function automatic int model_frame(input logic [DW-1:0] d, input bit pe, input bit pt,
                                     input bit s2, output logic [63:0] w);
    bit q[$];
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(d[i]);
    if (pe) q.push_back((($countones(d) % 2) == 1) ^ pt);
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
    w = '0;
    for (int k = 0; k < q.size() * CPB; k++) w[k] = q[k / CPB];
    return q.size() * CPB;
  endfunction

  function automatic logic [63:0] ones(input int n);
    logic [63:0] v = '0;
    for (int k = 0; k < n; k++) v[k] = 1'b1;
    return v;
  endfunction

  // Samples TX_OUT/Busy for n cycles; optionally scrambles the frame inputs meanwhile.
  task automatic capture(input int n, input bit scramble,
                         output logic [63:0] tx, output logic [63:0] bz);
    tx = '0; bz = '0;
    for (int k = 0; k < n; k++) begin
      tx[k] = TX_OUT;
      bz[k] = Busy;
      if (scramble) begin
        P_DATA  = DW'($urandom);
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
        STOP2   = 1'($urandom);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (TX_OUT !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", TX_OUT); end
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_tests++; if (DATA_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", DATA_READY); end
    DATA_VALID = 1'b0; rst = 1'b0;
    #1;
    n_tests++; if (DATA_READY !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", DATA_READY); end
    @(posedge clk); #1;
    n_tests++; if (TX_OUT !== 1'b1 || Busy !== 1'b0)
      begin n_fail++; $display("FAIL reset_idle: tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy); end
  endtask

  task automatic test_directed();
    logic [DW-1:0] d_t [4] = '{8'hA5, 8'hA5, 8'hA5, 8'h00};
    bit pe_t [4] = '{0, 1, 1, 1};
    bit pt_t [4] = '{0, 0, 1, 1};
    bit s2_t [4] = '{0, 0, 0, 1};
    logic [63:0] exp_w, tx, bz;
    int len;
    for (int t = 0; t < 4; t++) begin
      len = model_frame(d_t[t], pe_t[t], pt_t[t], s2_t[t], exp_w);
      P_DATA = d_t[t]; PAR_EN = pe_t[t]; PAR_TYP = pt_t[t]; STOP2 = s2_t[t]; DATA_VALID = 1'b1;
      n_tests++; if (DATA_READY !== 1'b1) begin n_fail++; $display("FAIL dir%0d_ready: got %b want 1", t, DATA_READY); end
      @(posedge clk); #1;
      DATA_VALID = 1'b0;
      capture(len, 1'b1, tx, bz);
      n_tests++; if (tx !== exp_w) begin n_fail++; $display("FAIL dir%0d_tx: got %h want %h", t, tx, exp_w); end
      n_tests++; if (bz !== ones(len)) begin n_fail++; $display("FAIL dir%0d_busy: got %h want %h", t, bz, ones(len)); end
      n_tests++; if (TX_OUT !== 1'b1 || Busy !== 1'b0 || DATA_READY !== 1'b1)
        begin n_fail++; $display("FAIL dir%0d_idle: tx=%b busy=%b rdy=%b want 1,0,1", t, TX_OUT, Busy, DATA_READY); end
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_w, tx, bz;
    logic [DW-1:0] d;
    bit pe, pt, s2;
    int len;
    for (int t = 0; t < 24; t++) begin
      d = DW'($urandom); pe = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
      len = model_frame(d, pe, pt, s2, exp_w);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; DATA_VALID = 1'b1;
      @(posedge clk); #1;
      DATA_VALID = 1'b0;
      capture(len, 1'b1, tx, bz);
      n_tests++; if (tx !== exp_w || bz !== ones(len))
        begin n_fail++; $display("FAIL rand%0d d=%h pe=%0d pt=%0d s2=%0d: tx=%h busy=%h want tx=%h busy=%h",
                                 t, d, pe, pt, s2, tx, bz, exp_w, ones(len)); end
      n_tests++; if (TX_OUT !== 1'b1 || Busy !== 1'b0)
        begin n_fail++; $display("FAIL rand%0d_end: tx=%b busy=%b want 1,0", t, TX_OUT, Busy); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w1, w2, tx, bz;
    int l1, l2;
    l1 = model_frame(8'h12, 1'b1, 1'b0, 1'b0, w1);
    l2 = model_frame(8'h34, 1'b0, 1'b0, 1'b1, w2);
    P_DATA = 8'h12; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b1;
    @(posedge clk); #1;
    P_DATA = 8'h34; PAR_EN = 1'b0; STOP2 = 1'b1;
    capture(l1, 1'b0, tx, bz);
    n_tests++; if (tx !== w1 || bz !== ones(l1))
      begin n_fail++; $display("FAIL b2b_frame1: tx=%h busy=%h want tx=%h busy=%h", tx, bz, w1, ones(l1)); end
    n_tests++; if (TX_OUT !== 1'b1 || Busy !== 1'b0 || DATA_READY !== 1'b1)
      begin n_fail++; $display("FAIL b2b_gap: tx=%b busy=%b rdy=%b want 1,0,1", TX_OUT, Busy, DATA_READY); end
    @(posedge clk); #1;
    DATA_VALID = 1'b0;
    capture(l2, 1'b0, tx, bz);
    n_tests++; if (tx !== w2 || bz !== ones(l2))
      begin n_fail++; $display("FAIL b2b_frame2: tx=%h busy=%h want tx=%h busy=%h", tx, bz, w2, ones(l2)); end
    n_tests++; if (TX_OUT !== 1'b1 || Busy !== 1'b0)
      begin n_fail++; $display("FAIL b2b_end: tx=%b busy=%b want 1,0", TX_OUT, Busy); end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] w, tx, bz;
    int len;
    P_DATA = 8'hFF; PAR_EN = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b1;
    @(posedge clk); #1;
    DATA_VALID = 1'b0;
    capture(15, 1'b0, tx, bz);
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (TX_OUT !== 1'b1 || Busy !== 1'b0 || DATA_READY !== 1'b0)
      begin n_fail++; $display("FAIL midrst: tx=%b busy=%b rdy=%b want 1,0,0", TX_OUT, Busy, DATA_READY); end
    rst = 1'b0;
    #1;
    n_tests++; if (DATA_READY !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", DATA_READY); end
    capture(12, 1'b0, tx, bz);
    n_tests++; if (tx !== ones(12) || bz !== 64'd0)
      begin n_fail++; $display("FAIL midrst_noretx: tx=%h busy=%h want tx=%h busy=0", tx, bz, ones(12)); end
    len = model_frame(8'h55, 1'b0, 1'b0, 1'b0, w);
    P_DATA = 8'h55; DATA_VALID = 1'b1;
    @(posedge clk); #1;
    DATA_VALID = 1'b0;
    capture(len, 1'b1, tx, bz);
    n_tests++; if (tx !== w || bz !== ones(len))
      begin n_fail++; $display("FAIL midrst_next: tx=%h busy=%h want tx=%h busy=%h", tx, bz, w, ones(len)); end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    logic [63:0] tx, bz, w;
    int brk_len;
    brk_len = (DW + 3) * CPB;
    w = '0;
    for (int k = brk_len; k < brk_len + CPB; k++) w[k] = 1'b1;
    P_DATA = 8'h0F; PAR_EN = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b1; BRK = 1'b1;
    @(posedge clk); #1;
    BRK = 1'b0; DATA_VALID = 1'b0;
    n_tests++; if (DATA_READY !== 1'b0) begin n_fail++; $display("FAIL brk_ready: got %b want 0", DATA_READY); end
    capture(brk_len + CPB, 1'b0, tx, bz);
    n_tests++; if (tx !== w || bz !== ones(brk_len + CPB))
      begin n_fail++; $display("FAIL brk_wave: tx=%h busy=%h want tx=%h busy=%h", tx, bz, w, ones(brk_len + CPB)); end
    n_tests++; if (TX_OUT !== 1'b1 || Busy !== 1'b0 || DATA_READY !== 1'b1)
      begin n_fail++; $display("FAIL brk_idle: tx=%b busy=%b rdy=%b want 1,0,1", TX_OUT, Busy, DATA_READY); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
